// File: rtl/miriscv_lsu_pkg.sv
// rtl/miriscv_lsu_pkg.sv - LSU size encodings, load FSM states, store-buffer entry and lane helpers
package miriscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam int unsigned SB_ADDR_W = 32;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_LD_WAIT,
        LSU_LD_FLUSH
    } lsu_state_e;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [3:0]           be;
        logic [31:0]          data;
    } sb_entry_t;

    function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: return 4'b0001 << off;
            LDST_H, LDST_HU: return off[1] ? 4'b1100 : 4'b0011;
            default:         return 4'b1111;
        endcase
    endfunction

    // Replicate the stored byte/half across every lane so the byte enables alone pick it.
    function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] data);
        case (size)
            LDST_B, LDST_BU: return {4{data[7:0]}};
            LDST_H, LDST_HU: return {2{data[15:0]}};
            default:         return data;
        endcase
    endfunction

    function automatic logic [31:0] lsu_load_ext(input logic [2:0] size, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*off +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            LDST_B:  return {{24{b[7]}}, b};
            LDST_BU: return {24'h0, b};
            LDST_H:  return {{16{h[15]}}, h};
            LDST_HU: return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/miriscv_sb_fifo.sv
// rtl/miriscv_sb_fifo.sv - store-buffer FIFO of sb_entry_t with occupancy count
module miriscv_sb_fifo
    import miriscv_lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic                         push_i,
    input  sb_entry_t                    wdata_i,
    input  logic                         pop_i,
    output sb_entry_t                    rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    sb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/miriscv_lsu_sb.sv
// rtl/miriscv_lsu_sb.sv - load/store unit with zero-stall posted store buffer and blocking loads
module miriscv_lsu_sb
    import miriscv_lsu_pkg::*;
#(
    parameter int unsigned SB_DEPTH   = 2,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [2:0]            lsu_size_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [31:0]           lsu_data_i,
    input  logic                  lsu_kill_i,
    output logic                  lsu_stall_req_o,
    output logic [31:0]           lsu_data_o,
    output logic                  lsu_misaligned_o,
    output logic                  lsu_sb_empty_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [31:0]           data_wdata_o,
    input  logic [31:0]           data_rdata_i
);

    localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);

    lsu_state_e            state_q, state_d;
    logic [1:0]            ld_off_q, ld_off_d;
    logic [2:0]            ld_size_q, ld_size_d;
    logic                  is_half, is_word, misaligned, acc_ok, is_store, is_load;
    logic                  ld_stall;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  sb_push, sb_pop, sb_full, sb_empty;
    logic [CNT_W-1:0]      sb_count;
    sb_entry_t             sb_wentry, sb_head;

    // Reset gates the request decode so nothing is pushed or issued while arstn_i is low.
    always_comb begin
        is_half    = (lsu_size_i == LDST_H) || (lsu_size_i == LDST_HU);
        is_word    = (lsu_size_i == LDST_W);
        misaligned = arstn_i && lsu_req_i &&
                     ((is_half && lsu_addr_i[0]) || (is_word && (lsu_addr_i[1:0] != 2'b00)));
        acc_ok     = arstn_i && lsu_req_i && !misaligned && !lsu_kill_i;
        is_store   = acc_ok && lsu_we_i;
        is_load    = acc_ok && !lsu_we_i;
        word_addr  = {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
        sb_wentry.addr = SB_ADDR_W'(word_addr);
        sb_wentry.be   = lsu_be(lsu_size_i, lsu_addr_i[1:0]);
        sb_wentry.data = lsu_wdata(lsu_size_i, lsu_data_i);
        sb_push    = is_store && !sb_full;
    end

    miriscv_sb_fifo #(
        .DEPTH (SB_DEPTH)
    ) u_sb_fifo (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .push_i  (sb_push),
        .wdata_i (sb_wentry),
        .pop_i   (sb_pop),
        .rdata_o (sb_head),
        .full_o  (sb_full),
        .empty_o (sb_empty),
        .count_o (sb_count)
    );

    // Only one memory transaction is ever outstanding: drains and loads issue from IDLE alone.
    always_comb begin
        state_d      = state_q;
        ld_off_d     = ld_off_q;
        ld_size_d    = ld_size_q;
        ld_stall     = 1'b0;
        sb_pop       = 1'b0;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        lsu_data_o   = '0;
        unique case (state_q)
            LSU_IDLE: begin
                if (!sb_empty) begin
                    data_req_o   = 1'b1;
                    data_we_o    = 1'b1;
                    data_be_o    = sb_head.be;
                    data_addr_o  = sb_head.addr[ADDR_WIDTH-1:0];
                    data_wdata_o = sb_head.data;
                    sb_pop       = data_gnt_i;
                    ld_stall     = is_load;
                end else if (is_load) begin
                    data_req_o  = 1'b1;
                    data_be_o   = 4'hF;
                    data_addr_o = word_addr;
                    ld_stall    = 1'b1;
                    if (data_gnt_i) begin
                        state_d   = LSU_LD_WAIT;
                        ld_off_d  = lsu_addr_i[1:0];
                        ld_size_d = lsu_size_i;
                    end
                end
            end
            LSU_LD_WAIT: begin
                if (data_rvalid_i) begin
                    lsu_data_o = lsu_load_ext(ld_size_q, ld_off_q, data_rdata_i);
                    state_d    = LSU_IDLE;
                end else if (lsu_kill_i) begin
                    state_d = LSU_LD_FLUSH;
                end else begin
                    ld_stall = is_load;
                end
            end
            LSU_LD_FLUSH: begin
                ld_stall = is_load;
                if (data_rvalid_i) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    assign lsu_stall_req_o  = ld_stall || (is_store && sb_full);
    assign lsu_misaligned_o = misaligned;
    assign lsu_sb_empty_o   = (sb_count == '0);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= LSU_IDLE;
            ld_off_q  <= '0;
            ld_size_q <= '0;
        end else begin
            state_q   <= state_d;
            ld_off_q  <= ld_off_d;
            ld_size_q <= ld_size_d;
        end
    end

endmodule
